// File: rtl/submod_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : submod_dispatch_if
// Purpose  : Client-side request/response bundle of the submod dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
interface submod_dispatch_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic [WIDTH-1:0]         rsp_data;
    logic                     rsp_err;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/submod_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : submod_dispatch
// Purpose  : Round-robin dispatcher sharing one submod unit between requesters.
// Revision : 1.0 - initial release
// ============================================================================
module submod_dispatch #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    submod_dispatch_if.slave      bus,
    output logic                  unit_start,
    output logic [WIDTH-1:0]      unit_a,
    input  wire logic             unit_done,
    input  wire logic [WIDTH-1:0] unit_c,
    output logic                  busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam int                 c_CNT_W    = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [IDW:0]       c_NUM      = (IDW + 1)'(NUM_REQ);
    localparam logic [IDW-1:0]     c_ID_LAST  = IDW'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_id;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_unit_start;
    logic [WIDTH-1:0]   r_unit_a;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_data;
    logic               r_rsp_err;

    logic               w_found;
    logic [IDW-1:0]     w_winner;
    logic [IDW:0]       w_sum;
    logic [NUM_REQ-1:0] w_req_ready;

    // Search starts at r_rr_ptr and wraps, so the last served requester ranks lowest.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW + 1)'(k);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            if (!w_found && bus.req_valid[w_sum[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IDW-1:0];
            end
        end
    end

    // Gated by rst_n so the grant also vanishes the moment reset is asserted.
    always_comb begin
        w_req_ready = '0;
        if (rst_n && (r_state == c_IDLE) && w_found) begin
            w_req_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_cnt        <= '0;
            r_unit_start <= 1'b0;
            r_unit_a     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_unit_start <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_id         <= w_winner;
                        r_unit_a     <= bus.req_data[w_winner*WIDTH +: WIDTH];
                        r_unit_start <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    // Counter tracks cycles since the start pulse; done beats timeout.
                    r_cnt <= r_cnt + 1'b1;
                    if (unit_done) begin
                        r_rsp_data  <= unit_c;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_unit_a    <= '0;
                        r_rr_ptr    <= (r_id == c_ID_LAST) ? '0 : r_id + 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign unit_start    = r_unit_start;
    assign unit_a        = r_unit_a;
    assign busy          = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_submod_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_submod_dispatch
// Purpose  : Scoreboard bench for submod_dispatch with a behavioural unit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_submod_dispatch;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             unit_start;
    logic [WIDTH-1:0] unit_a;
    logic             unit_done;
    logic [WIDTH-1:0] unit_c;
    logic             busy;

    int errors = 0;
    int checks = 0;

    logic [IDW+WIDTH:0] exp_q[$];

    int               u_delay = 0;
    int               u_late  = 0;
    logic [WIDTH-1:0] u_val   = '0;

    submod_dispatch_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

    submod_dispatch #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .unit_start (unit_start),
        .unit_a     (unit_a),
        .unit_done  (unit_done),
        .unit_c     (unit_c),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 40) begin
            tick();
            settle();
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s: req_ready still 0 after 40 cycles, expected a grant", name);
        end
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            settle();
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s: rsp_valid still 0 after 40 cycles, expected 1", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            settle();
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still 1 after 40 cycles, expected 0", name);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        u_delay       = 0;
        u_late        = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Unit model: done pulse u_delay cycles after start, optional extra pulse u_late later.
    initial begin : p_unit
        int               d;
        int               l;
        logic [WIDTH-1:0] v;
        unit_done = 1'b0;
        unit_c    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (unit_start === 1'b1) begin
                d = u_delay;
                l = u_late;
                v = u_val;
                if (d > 0) begin
                    repeat (d) @(posedge clk);
                    #1;
                    unit_done = 1'b1;
                    unit_c    = v;
                    @(posedge clk);
                    #1;
                    unit_done = 1'b0;
                    unit_c    = '0;
                    if (l > 0) begin
                        repeat (l - 1) @(posedge clk);
                        #1;
                        unit_done = 1'b1;
                        unit_c    = v;
                        @(posedge clk);
                        #1;
                        unit_done = 1'b0;
                        unit_c    = '0;
                    end
                end
            end
        end
    end

    initial begin : p_monitor
        logic [IDW+WIDTH:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id=%0d data=0x%0h err=%0b, expected no response",
                             bus.rsp_id, bus.rsp_data, bus.rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_payload", 32'({bus.rsp_id, bus.rsp_data, bus.rsp_err}), 32'(e));
                end
            end
        end
    end

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int n;

        // Reset values
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_unit_start", 32'(unit_start), 32'h0);
        chk("rst_unit_a", 32'(unit_a), 32'h0);
        chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        do_reset();

        // Single request, minimum latency
        bus.req_valid = 4'b0100;
        bus.req_data  = {4'h0, 4'h9, 4'h0, 4'h0};
        bus.rsp_ready = 1'b1;
        u_delay       = 1;
        u_val         = 4'h1;
        settle();
        chk("single_grant_c0", 32'(bus.req_ready), 32'b0100);
        exp_q.push_back({2'd2, 4'h1, 1'b0});
        tick();
        bus.req_valid = '0;
        settle();
        chk("single_start_c1", 32'(unit_start), 32'h1);
        chk("single_unit_a_c1", 32'(unit_a), 32'h9);
        chk("single_busy_c1", 32'(busy), 32'h1);
        tick();
        settle();
        chk("single_c2", 32'({unit_start, bus.rsp_valid, unit_a}), 32'({1'b0, 1'b0, 4'h9}));
        tick();
        settle();
        chk("single_rsp_valid_c3", 32'(bus.rsp_valid), 32'h1);
        tick();
        settle();
        chk("single_c4_idle", 32'({bus.rsp_valid, busy, unit_a}), 32'h0);

        // Round-robin fairness from rr_ptr=0
        do_reset();
        bus.req_data  = {4'hD, 4'hC, 4'hB, 4'hA};
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        u_delay       = 1;
        for (int g = 0; g < 5; g++) begin
            u_val = 4'(g * 3 + 1);
            wait_ready("rr_wait");
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << (g % 4)));
            exp_q.push_back({2'(g % 4), 4'(g * 3 + 1), 1'b0});
            tick();
            settle();
            chk("rr_unit_a", 32'(unit_a), 32'(10 + g % 4));
        end
        bus.req_valid = '0;
        wait_idle("rr_idle");

        // Timeout (rr_ptr=1), late done pulses in RESP and IDLE
        bus.req_valid = 4'b0010;
        bus.req_data  = {4'h0, 4'h0, 4'h5, 4'h0};
        u_delay       = 16;
        u_late        = 2;
        u_val         = 4'hF;
        wait_ready("to_wait");
        chk("to_grant", 32'(bus.req_ready), 32'b0010);
        exp_q.push_back({2'd1, 4'h0, 1'b1});
        tick();
        bus.req_valid = '0;
        settle();
        chk("to_start", 32'(unit_start), 32'h1);
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            settle();
            n++;
        end
        chk("to_latency", 32'(n), 32'd16);
        chk("to_err_data", 32'({bus.rsp_err, bus.rsp_data}), 32'({1'b1, 4'h0}));
        repeat (4) tick();
        settle();
        chk("to_late_ignored", 32'({busy, bus.rsp_valid}), 32'h0);
        u_late = 0;

        // Backpressure (rr_ptr=2): requester 3 wins, then requester 0
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1001;
        bus.req_data  = {4'h3, 4'h0, 4'h0, 4'h4};
        u_delay       = 1;
        u_val         = 4'h7;
        wait_ready("bp_wait");
        chk("bp_grant", 32'(bus.req_ready), 32'b1000);
        exp_q.push_back({2'd3, 4'h7, 1'b0});
        tick();
        bus.req_valid = 4'b0001;
        settle();
        chk("bp_unit_a", 32'(unit_a), 32'h3);
        wait_rsp("bp_rsp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err}),
                32'({1'b1, 2'd3, 4'h7, 1'b0}));
            chk("bp_no_grant", 32'({busy, bus.req_ready}), 32'({1'b1, 4'b0000}));
            tick();
            settle();
        end
        bus.rsp_ready = 1'b1;
        u_val         = 4'h2;
        tick();
        settle();
        chk("bp_next_grant", 32'({bus.rsp_valid, bus.req_ready}), 32'({1'b0, 4'b0001}));
        exp_q.push_back({2'd0, 4'h2, 1'b0});
        tick();
        bus.req_valid = '0;
        settle();
        wait_idle("bp_idle");

        // Done coincident with timeout (rr_ptr=1)
        bus.req_valid = 4'b0100;
        bus.req_data  = {4'h0, 4'h6, 4'h0, 4'h0};
        u_delay       = 15;
        u_val         = 4'hA;
        wait_ready("co_wait");
        chk("co_grant", 32'(bus.req_ready), 32'b0100);
        exp_q.push_back({2'd2, 4'hA, 1'b0});
        tick();
        bus.req_valid = '0;
        settle();
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            settle();
            n++;
        end
        chk("co_latency", 32'(n), 32'd16);
        chk("co_err_data", 32'({bus.rsp_err, bus.rsp_data}), 32'({1'b0, 4'hA}));
        wait_idle("co_idle");

        // Reset mid-operation (rr_ptr=3 so requester 3 wins before reset)
        bus.req_valid = 4'b1010;
        bus.req_data  = {4'h8, 4'h0, 4'h4, 4'h0};
        u_delay       = 0;
        wait_ready("mr_wait");
        chk("mr_grant_pre", 32'(bus.req_ready), 32'b1000);
        repeat (3) tick();
        settle();
        chk("mr_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_abort", 32'({busy, bus.rsp_valid, unit_a, bus.req_ready}), 32'h0);
        tick();
        tick();
        u_delay = 1;
        u_val   = 4'h4;
        rst_n   = 1'b1;
        settle();
        chk("mr_grant_post", 32'(bus.req_ready), 32'b0010);
        exp_q.push_back({2'd1, 4'h4, 1'b0});
        tick();
        bus.req_valid = '0;
        settle();
        chk("mr_unit_a_post", 32'(unit_a), 32'h4);
        wait_idle("mr_idle");

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
